// File: rtl/CDB_types.sv
// Shared CDB / reservation-station types, widths and small helpers.
package CDB_types;

    localparam int CDB_NUM   = 2;
    localparam int P_REG_NUM = 64;
    localparam int EBR_NUM   = 4;
    localparam int ROB_DEPTH = 16;

    localparam int PREG_W = $clog2(P_REG_NUM);
    localparam int EBR_W  = $clog2(EBR_NUM);
    localparam int ROB_W  = $clog2(ROB_DEPTH) + 1;

    typedef struct packed {
        logic [EBR_NUM-1:0]            valid;
        logic [EBR_NUM-1:0][ROB_W-1:0] rob_tags;
    } depen_t;

    typedef struct packed {
        logic              valid;
        logic [7:0]        op;
        logic [PREG_W-1:0] pd_idx;
        logic [PREG_W-1:0] ps1_idx;
        logic              ps1_valid;
        logic [PREG_W-1:0] ps2_idx;
        logic              ps2_valid;
        logic [ROB_W-1:0]  rob_tag;
        depen_t            depen;
    } res_station_t;

    // Per-lane select result: whether the lane fires and what it carries.
    typedef struct packed {
        logic         valid;
        res_station_t data;
    } ms_issue_sel_t;

    // Mark sources ready that match a qualified broadcast this cycle.
    function automatic res_station_t cdb_wake(
        input res_station_t                      e,
        input logic [CDB_NUM-1:0]                cdb_v,
        input logic [CDB_NUM-1:0][PREG_W-1:0]    cdb_pd
    );
        res_station_t r;
        r = e;
        for (int c = 0; c < CDB_NUM; c++) begin
            if (cdb_v[c]) begin
                if (e.ps1_idx == cdb_pd[c]) r.ps1_valid = 1'b1;
                if (e.ps2_idx == cdb_pd[c]) r.ps2_valid = 1'b1;
            end
        end
        return r;
    endfunction

    // True when an entry depends on the given branch slot / ROB tag.
    function automatic logic depen_match(
        input depen_t           d,
        input logic [EBR_W-1:0] idx,
        input logic [ROB_W-1:0] rob
    );
        return d.valid[idx] && (d.rob_tags[idx] == rob);
    endfunction

endpackage

// File: rtl/res_station_ms_age_select.sv
// Age-matrix select logic for res_station_ms is implemented in rs_age_select.sv.

// File: rtl/rs_age_select.sv
// Oldest-first multi-lane select driven by an age matrix.
// A ready slot's rank is the number of ready slots older than it; the
// rank-k slot goes to the k-th lane (ascending) whose fu_ready is high.
module rs_age_select #(
    parameter int RES_DEPTH = 8,
    parameter int ISSUE_W   = 2
) (
    input  logic [RES_DEPTH-1:0][RES_DEPTH-1:0] older,
    input  logic [RES_DEPTH-1:0]                ready,
    input  logic [ISSUE_W-1:0]                  fu_ready,
    output logic [ISSUE_W-1:0][RES_DEPTH-1:0]   grant
);

    localparam int CNT_W = $clog2(RES_DEPTH) + 1;

    logic [RES_DEPTH-1:0][CNT_W-1:0] rank;
    logic [ISSUE_W-1:0][CNT_W-1:0]   order;

    // Rank each slot by the count of older ready slots.
    always_comb begin
        rank = '0;
        for (int r = 0; r < RES_DEPTH; r++) begin
            for (int j = 0; j < RES_DEPTH; j++) begin
                if (ready[j] && older[j][r]) rank[r] = rank[r] + CNT_W'(1);
            end
        end
    end

    // Position of each lane among the lanes that can accept this cycle.
    always_comb begin
        order = '0;
        for (int l = 0; l < ISSUE_W; l++) begin
            for (int m = 0; m < l; m++) begin
                if (fu_ready[m]) order[l] = order[l] + CNT_W'(1);
            end
        end
    end

    // Match slot rank to lane position.
    always_comb begin
        grant = '0;
        for (int l = 0; l < ISSUE_W; l++) begin
            for (int r = 0; r < RES_DEPTH; r++) begin
                grant[l][r] = fu_ready[l] && ready[r] && (rank[r] == order[l]);
            end
        end
    end

endmodule

// File: rtl/res_station_ms.sv
// Multi-enqueue / multi-issue reservation station with unordered slots,
// age-matrix oldest-first select, CDB wakeup and branch flush / resolve.
module res_station_ms
    import CDB_types::*;
#(
    parameter int RES_DEPTH = 8,
    parameter int ENQ_W     = 2,
    parameter int ISSUE_W   = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [ENQ_W-1:0]                   enq_valid,
    input  res_station_t [ENQ_W-1:0]           enq_data,
    output logic                               enq_ready,
    input  logic [CDB_NUM-1:0]                 cdb_valid,
    input  logic [CDB_NUM-1:0][PREG_W-1:0]     cdb_pd_array,
    input  logic [ISSUE_W-1:0]                 fu_ready,
    input  logic                               early_flush,
    input  logic                               up,
    input  logic [EBR_W-1:0]                   recover_idx,
    input  logic [ROB_W-1:0]                   depen_rob,
    output logic [ISSUE_W-1:0]                 iss_valid,
    output res_station_t [ISSUE_W-1:0]         iss_data,
    output logic [$clog2(RES_DEPTH):0]         free_cnt,
    output logic                               empty
);

    localparam int CNT_W = $clog2(RES_DEPTH) + 1;

    res_station_t [RES_DEPTH-1:0]        entries_q, entries_d;
    logic [RES_DEPTH-1:0][RES_DEPTH-1:0] older_q, older_d;
    logic [CNT_W-1:0]                    free_cnt_q, free_cnt_d;

    logic [RES_DEPTH-1:0]              ready, issued, taken, prior;
    logic [ISSUE_W-1:0]                fu_eff;
    logic [ISSUE_W-1:0][RES_DEPTH-1:0] grant;
    ms_issue_sel_t [ISSUE_W-1:0]       lane_sel;
    logic [ENQ_W-1:0]                  enq_acc;
    logic [ENQ_W-1:0][RES_DEPTH-1:0]   alloc_oh;
    logic [CNT_W-1:0]                  n_free, n_alloc;

    assign enq_ready = free_cnt_q >= CNT_W'(ENQ_W);
    assign empty     = free_cnt_q == CNT_W'(RES_DEPTH);
    assign free_cnt  = free_cnt_q;
    assign enq_acc   = enq_valid & {ENQ_W{enq_ready & ~early_flush}};
    assign fu_eff    = early_flush ? '0 : fu_ready;

    // Ready vector from registered state only (no wakeup bypass).
    always_comb begin
        ready = '0;
        for (int i = 0; i < RES_DEPTH; i++) begin
            ready[i] = entries_q[i].valid && entries_q[i].ps1_valid && entries_q[i].ps2_valid;
        end
    end

    rs_age_select #(
        .RES_DEPTH (RES_DEPTH),
        .ISSUE_W   (ISSUE_W)
    ) u_age_select (
        .older    (older_q),
        .ready    (ready),
        .fu_ready (fu_eff),
        .grant    (grant)
    );

    // Mux granted entries onto lanes; idle lanes carry all zeros.
    always_comb begin
        lane_sel = '0;
        issued   = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                if (grant[k][i]) begin
                    lane_sel[k].valid = 1'b1;
                    lane_sel[k].data  = lane_sel[k].data | entries_q[i];
                    issued[i]         = 1'b1;
                end
            end
        end
        for (int k = 0; k < ISSUE_W; k++) begin
            iss_valid[k] = lane_sel[k].valid;
            iss_data[k]  = lane_sel[k].data;
        end
    end

    // Give accepted ports the lowest free slots in port order.
    always_comb begin
        taken    = '0;
        alloc_oh = '0;
        for (int p = 0; p < ENQ_W; p++) begin
            if (enq_acc[p]) begin
                for (int i = 0; i < RES_DEPTH; i++) begin
                    if (!(|alloc_oh[p]) && !entries_q[i].valid && !taken[i]) begin
                        alloc_oh[p][i] = 1'b1;
                        taken[i]       = 1'b1;
                    end
                end
            end
        end
    end

    // Slot update: wakeup, resolve, flush, issue free, then enqueue writes.
    always_comb begin
        entries_d = entries_q;
        n_free    = '0;
        n_alloc   = '0;
        for (int i = 0; i < RES_DEPTH; i++) begin
            if (entries_q[i].valid) begin
                entries_d[i] = cdb_wake(entries_q[i], cdb_valid, cdb_pd_array);
                if (depen_match(entries_q[i].depen, recover_idx, depen_rob)) begin
                    if (early_flush)
                        entries_d[i].valid = 1'b0;
                    else if (up)
                        entries_d[i].depen.valid[recover_idx] = 1'b0;
                end
                if (issued[i]) entries_d[i].valid = 1'b0;
                if (!entries_d[i].valid) n_free = n_free + CNT_W'(1);
            end
            for (int p = 0; p < ENQ_W; p++) begin
                if (alloc_oh[p][i]) begin
                    entries_d[i]       = cdb_wake(enq_data[p], cdb_valid, cdb_pd_array);
                    entries_d[i].valid = 1'b1;
                    n_alloc            = n_alloc + CNT_W'(1);
                end
            end
        end
        free_cnt_d = free_cnt_q + n_free - n_alloc;
    end

    // New slots are younger than everything resident and than lower ports.
    always_comb begin
        older_d = older_q;
        prior   = '0;
        for (int p = 0; p < ENQ_W; p++) begin
            for (int s = 0; s < RES_DEPTH; s++) begin
                if (alloc_oh[p][s]) older_d[s] = '0;
            end
        end
        for (int p = 0; p < ENQ_W; p++) begin
            for (int s = 0; s < RES_DEPTH; s++) begin
                if (alloc_oh[p][s]) begin
                    for (int x = 0; x < RES_DEPTH; x++) begin
                        older_d[x][s] = entries_q[x].valid || prior[x];
                    end
                end
            end
            prior = prior | alloc_oh[p];
        end
    end

    // State registers; reset drops every entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q  <= '0;
            older_q    <= '0;
            free_cnt_q <= CNT_W'(RES_DEPTH);
        end else begin
            entries_q  <= entries_d;
            older_q    <= older_d;
            free_cnt_q <= free_cnt_d;
        end
    end

endmodule

// File: tb/tb_res_station_ms.sv
// Directed bench for res_station_ms: per-cycle vector table plus
// hand-written sequences for reset, full, flush and resolve.
module tb_res_station_ms;
    import CDB_types::*;

    logic                           clk;
    logic                           rst_n;
    logic [1:0]                     enq_valid;
    res_station_t [1:0]             enq_data;
    logic                           enq_ready;
    logic [CDB_NUM-1:0]             cdb_valid;
    logic [CDB_NUM-1:0][PREG_W-1:0] cdb_pd_array;
    logic [1:0]                     fu_ready;
    logic                           early_flush;
    logic                           up;
    logic [EBR_W-1:0]               recover_idx;
    logic [ROB_W-1:0]               depen_rob;
    logic [1:0]                     iss_valid;
    res_station_t [1:0]             iss_data;
    logic [3:0]                     free_cnt;
    logic                           empty;

    int n_checks = 0;
    int n_errors = 0;

    res_station_ms #(.RES_DEPTH(8), .ENQ_W(2), .ISSUE_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enq_valid    (enq_valid),
        .enq_data     (enq_data),
        .enq_ready    (enq_ready),
        .cdb_valid    (cdb_valid),
        .cdb_pd_array (cdb_pd_array),
        .fu_ready     (fu_ready),
        .early_flush  (early_flush),
        .up           (up),
        .recover_idx  (recover_idx),
        .depen_rob    (depen_rob),
        .iss_valid    (iss_valid),
        .iss_data     (iss_data),
        .free_cnt     (free_cnt),
        .empty        (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] op;
        logic [5:0] t1;
        logic       v1;
        logic [5:0] t2;
        logic       v2;
    } enq_t;

    typedef struct {
        logic [1:0] ev;
        enq_t       e0;
        enq_t       e1;
        logic [1:0] cv;
        logic [5:0] c0;
        logic [5:0] c1;
        logic [1:0] fu;
        logic [1:0] x_iv;
        logic [7:0] x_op0;
        logic [7:0] x_op1;
        logic [3:0] x_free;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];
    enq_t z;

    function automatic enq_t E(input logic [7:0] op, input logic [5:0] t1, input logic v1,
                               input logic [5:0] t2, input logic v2);
        enq_t e;
        e.op = op; e.t1 = t1; e.v1 = v1; e.t2 = t2; e.v2 = v2;
        return e;
    endfunction

    function automatic vec_t V(input logic [1:0] ev, input enq_t e0, input enq_t e1,
                               input logic [1:0] cv, input logic [5:0] c0, input logic [5:0] c1,
                               input logic [1:0] fu, input logic [1:0] x_iv,
                               input logic [7:0] x_op0, input logic [7:0] x_op1,
                               input logic [3:0] x_free);
        vec_t v;
        v.ev = ev; v.e0 = e0; v.e1 = e1; v.cv = cv; v.c0 = c0; v.c1 = c1; v.fu = fu;
        v.x_iv = x_iv; v.x_op0 = x_op0; v.x_op1 = x_op1; v.x_free = x_free;
        return v;
    endfunction

    // Payload .valid left at 0 so the station must force it on write.
    function automatic res_station_t mk(input logic [7:0] op, input logic [5:0] t1, input logic v1,
                                        input logic [5:0] t2, input logic v2,
                                        input logic [3:0] dv, input logic [4:0] dt);
        res_station_t r;
        r = '0;
        r.op        = op;
        r.pd_idx    = op[5:0];
        r.ps1_idx   = t1;
        r.ps1_valid = v1;
        r.ps2_idx   = t2;
        r.ps2_valid = v2;
        r.depen.valid = dv;
        for (int b = 0; b < EBR_NUM; b++) r.depen.rob_tags[b] = dt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        enq_valid    = 2'b00;
        enq_data     = '0;
        cdb_valid    = '0;
        cdb_pd_array = '0;
        fu_ready     = 2'b11;
        early_flush  = 1'b0;
        up           = 1'b0;
        recover_idx  = '0;
        depen_rob    = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic load_branch_set();
        cyc();
        fu_ready    = 2'b00;
        enq_valid   = 2'b11;
        enq_data[0] = mk(8'd40, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0010, 5'd2);
        enq_data[1] = mk(8'd41, 6'd41, 1'b0, 6'd1, 1'b1, 4'b0010, 5'd3);
        cyc();
        fu_ready    = 2'b00;
        enq_valid   = 2'b11;
        enq_data[0] = mk(8'd42, 6'd42, 1'b0, 6'd1, 1'b1, 4'b0001, 5'd3);
        enq_data[1] = mk(8'd43, 6'd43, 1'b0, 6'd1, 1'b1, 4'b0010, 5'd3);
        #1;
        chk("load_free", 32'(free_cnt), 32'd6);
    endtask

    initial begin
        z = '0;
        vecs[0]  = V(2'b01, E(1,1,1,2,1),   z,             2'b00, 0, 0,  2'b11, 2'b00, 0, 0, 8);
        vecs[1]  = V(2'b00, z,              z,             2'b00, 0, 0,  2'b11, 2'b01, 1, 0, 7);
        vecs[2]  = V(2'b00, z,              z,             2'b00, 0, 0,  2'b11, 2'b00, 0, 0, 8);
        vecs[3]  = V(2'b01, E(2,5,0,3,1),   z,             2'b00, 0, 0,  2'b11, 2'b00, 0, 0, 8);
        vecs[4]  = V(2'b01, E(3,4,1,6,1),   z,             2'b00, 0, 0,  2'b11, 2'b00, 0, 0, 7);
        vecs[5]  = V(2'b00, z,              z,             2'b01, 5, 0,  2'b11, 2'b01, 3, 0, 6);
        vecs[6]  = V(2'b00, z,              z,             2'b00, 0, 0,  2'b11, 2'b01, 2, 0, 7);
        vecs[7]  = V(2'b00, z,              z,             2'b00, 0, 0,  2'b11, 2'b00, 0, 0, 8);
        vecs[8]  = V(2'b11, E(4,1,1,1,1),   E(5,1,1,1,1),  2'b00, 0, 0,  2'b11, 2'b00, 0, 0, 8);
        vecs[9]  = V(2'b01, E(6,1,1,1,1),   z,             2'b00, 0, 0,  2'b00, 2'b00, 0, 0, 6);
        vecs[10] = V(2'b00, z,              z,             2'b00, 0, 0,  2'b10, 2'b10, 0, 4, 5);
        vecs[11] = V(2'b00, z,              z,             2'b00, 0, 0,  2'b11, 2'b11, 5, 6, 6);
        vecs[12] = V(2'b00, z,              z,             2'b00, 0, 0,  2'b11, 2'b00, 0, 0, 8);
        vecs[13] = V(2'b01, E(7,1,1,9,0),   z,             2'b01, 9, 0,  2'b11, 2'b00, 0, 0, 8);
        vecs[14] = V(2'b00, z,              z,             2'b00, 0, 0,  2'b11, 2'b01, 7, 0, 7);
        vecs[15] = V(2'b00, z,              z,             2'b00, 0, 0,  2'b11, 2'b00, 0, 0, 8);
        vecs[16] = V(2'b11, E(8,10,0,2,1),  E(9,11,0,2,1), 2'b10, 10, 11, 2'b11, 2'b00, 0, 0, 8);
        vecs[17] = V(2'b00, z,              z,             2'b00, 0, 0,  2'b11, 2'b01, 9, 0, 6);
        vecs[18] = V(2'b00, z,              z,             2'b01, 10, 0, 2'b11, 2'b00, 0, 0, 7);
        vecs[19] = V(2'b00, z,              z,             2'b00, 0, 0,  2'b11, 2'b01, 8, 0, 7);
        vecs[20] = V(2'b00, z,              z,             2'b00, 0, 0,  2'b11, 2'b00, 0, 0, 8);
        vecs[21] = V(2'b11, E(10,1,1,1,1),  E(11,1,1,1,1), 2'b00, 0, 0,  2'b11, 2'b00, 0, 0, 8);
        vecs[22] = V(2'b00, z,              z,             2'b00, 0, 0,  2'b01, 2'b01, 10, 0, 6);
        vecs[23] = V(2'b00, z,              z,             2'b00, 0, 0,  2'b01, 2'b01, 11, 0, 7);
        vecs[24] = V(2'b00, z,              z,             2'b00, 0, 0,  2'b11, 2'b00, 0, 0, 8);

        // Reset asserted mid-cycle with an entry resident
        rst_n = 1'b0;
        idle();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        enq_valid   = 2'b01;
        enq_data[0] = mk(8'd99, 6'd50, 1'b0, 6'd1, 1'b1, 4'b0000, 5'd0);
        cyc();
        #1;
        chk("pre_reset_free", 32'(free_cnt), 32'd7);
        chk("pre_reset_empty", 32'(empty), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_free", 32'(free_cnt), 32'd8);
        chk("async_reset_empty", 32'(empty), 32'd1);
        chk("async_reset_enq_ready", 32'(enq_ready), 32'd1);
        chk("async_reset_iss_valid", 32'(iss_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Per-cycle vector table
        for (int n = 0; n < NV; n++) begin
            @(negedge clk);
            idle();
            enq_valid       = vecs[n].ev;
            enq_data[0]     = mk(vecs[n].e0.op, vecs[n].e0.t1, vecs[n].e0.v1, vecs[n].e0.t2, vecs[n].e0.v2, 4'b0, 5'd0);
            enq_data[1]     = mk(vecs[n].e1.op, vecs[n].e1.t1, vecs[n].e1.v1, vecs[n].e1.t2, vecs[n].e1.v2, 4'b0, 5'd0);
            cdb_valid       = vecs[n].cv;
            cdb_pd_array[0] = vecs[n].c0;
            cdb_pd_array[1] = vecs[n].c1;
            fu_ready        = vecs[n].fu;
            #1;
            chk($sformatf("v%0d iss_valid", n), 32'(iss_valid), 32'(vecs[n].x_iv));
            chk($sformatf("v%0d free_cnt", n), 32'(free_cnt), 32'(vecs[n].x_free));
            chk($sformatf("v%0d enq_ready", n), 32'(enq_ready), 32'(vecs[n].x_free >= 4'd2));
            chk($sformatf("v%0d empty", n), 32'(empty), 32'(vecs[n].x_free == 4'd8));
            for (int k = 0; k < 2; k++) begin
                if (vecs[n].x_iv[k]) begin
                    chk($sformatf("v%0d lane%0d op", n, k), 32'(iss_data[k].op),
                        32'(k == 0 ? vecs[n].x_op0 : vecs[n].x_op1));
                    chk($sformatf("v%0d lane%0d valid_bit", n, k), 32'(iss_data[k].valid), 32'd1);
                end else begin
                    chk($sformatf("v%0d lane%0d data_zero", n, k), 32'(iss_data[k] == '0), 32'd1);
                end
            end
        end

        // Full station: fill with unready entries, ignored enqueue, drain by wakeup
        do_reset();
        for (int f = 0; f < 4; f++) begin
            cyc();
            enq_valid   = 2'b11;
            enq_data[0] = mk(8'(20 + 2*f), 6'(20 + 2*f), 1'b0, 6'd1, 1'b1, 4'b0, 5'd0);
            enq_data[1] = mk(8'(21 + 2*f), 6'(21 + 2*f), 1'b0, 6'd1, 1'b1, 4'b0, 5'd0);
        end
        cyc();
        enq_valid   = 2'b11;
        enq_data[0] = mk(8'd30, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0, 5'd0);
        enq_data[1] = mk(8'd31, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0, 5'd0);
        #1;
        chk("full_free", 32'(free_cnt), 32'd0);
        chk("full_enq_ready", 32'(enq_ready), 32'd0);
        chk("full_empty", 32'(empty), 32'd0);
        chk("full_iss_valid", 32'(iss_valid), 32'd0);
        cyc();
        cdb_valid       = 2'b01;
        cdb_pd_array[0] = 6'd20;
        #1;
        chk("full_ignored_free", 32'(free_cnt), 32'd0);
        chk("full_ignored_iss", 32'(iss_valid), 32'd0);
        cyc();
        cdb_valid       = 2'b01;
        cdb_pd_array[0] = 6'd21;
        #1;
        chk("full_drain1_iss", 32'(iss_valid), 32'd1);
        chk("full_drain1_op", 32'(iss_data[0].op), 32'd20);
        cyc();
        #1;
        chk("full_one_free", 32'(free_cnt), 32'd1);
        chk("full_one_enq_ready", 32'(enq_ready), 32'd0);
        chk("full_drain2_op", 32'(iss_data[0].op), 32'd21);
        cyc();
        #1;
        chk("full_two_free", 32'(free_cnt), 32'd2);
        chk("full_two_enq_ready", 32'(enq_ready), 32'd1);

        // Early flush of branch-dependent entries; same-cycle enqueue suppressed
        do_reset();
        load_branch_set();
        cyc();
        early_flush = 1'b1;
        recover_idx = 2'd1;
        depen_rob   = 5'd3;
        fu_ready    = 2'b11;
        enq_valid   = 2'b01;
        enq_data[0] = mk(8'd44, 6'd1, 1'b1, 6'd1, 1'b1, 4'b0, 5'd0);
        #1;
        chk("flush_iss_forced_off", 32'(iss_valid), 32'd0);
        chk("flush_free_before", 32'(free_cnt), 32'd4);
        cyc();
        #1;
        chk("flush_free_after", 32'(free_cnt), 32'd6);
        chk("flush_survivor_iss", 32'(iss_valid), 32'd1);
        chk("flush_survivor_op", 32'(iss_data[0].op), 32'd40);
        cyc();
        #1;
        chk("flush_free_final", 32'(free_cnt), 32'd7);
        chk("flush_iss_idle", 32'(iss_valid), 32'd0);

        // Correct resolve: matching entries stay with the dependency bit cleared
        do_reset();
        load_branch_set();
        cyc();
        up          = 1'b1;
        recover_idx = 2'd1;
        depen_rob   = 5'd3;
        #1;
        chk("up_iss_op40", 32'(iss_valid), 32'd1);
        chk("up_op40_op", 32'(iss_data[0].op), 32'd40);
        chk("up_op40_depen", 32'(iss_data[0].depen.valid), 32'h2);
        cyc();
        cdb_valid       = 2'b11;
        cdb_pd_array[0] = 6'd41;
        cdb_pd_array[1] = 6'd43;
        #1;
        chk("up_free_kept", 32'(free_cnt), 32'd5);
        chk("up_iss_idle", 32'(iss_valid), 32'd0);
        cyc();
        #1;
        chk("up_dual_iss", 32'(iss_valid), 32'd3);
        chk("up_lane0_op", 32'(iss_data[0].op), 32'd41);
        chk("up_lane1_op", 32'(iss_data[1].op), 32'd43);
        chk("up_lane0_depen", 32'(iss_data[0].depen.valid), 32'h0);
        chk("up_lane1_depen", 32'(iss_data[1].depen.valid), 32'h0);
        cyc();
        #1;
        chk("up_free_final", 32'(free_cnt), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/res_station_ms.md
# res_station_ms

Multi-issue, multi-enqueue reservation station: the parametrised successor to the single-port in-order-scan station. It sits between rename/dispatch and a group of ISSUE_W functional-unit lanes. Entries live in unordered slots. An age matrix selects the oldest ready entries, so issue is oldest-first without compaction and without head/tail pointers. The station wakes operands from qualified CDB broadcasts, including same-cycle capture at enqueue, and supports early branch flush and branch-resolve dependency clearing.

## Interface
Parameters:
- RES_DEPTH, 8: number of entry slots (≥2, power of 2 not required)
- ENQ_W, 2: dispatch ports per cycle
- ISSUE_W, 2: issue lanes per cycle (≤ RES_DEPTH)

Ports:
- clk, in, 1: clock
- rst_n, in, 1: reset. One clock; reset is asynchronous and active-low.
- enq_valid, in, [ENQ_W]: dispatch request per port
- enq_data, in, res_station_t [ENQ_W]: entry payload; .valid is ignored and forced to 1 on write
- enq_ready, out, 1: high when at least ENQ_W slots are free (all-or-nothing)
- cdb_valid, in, [CDB_NUM]: broadcast qualifier per CDB lane
- cdb_pd_array, in, [CDB_NUM][$clog2(P_REG_NUM)]: broadcast physical destination tags
- fu_ready, in, [ISSUE_W]: lane k can accept an instruction this cycle
- early_flush, in, 1: mispredict kill
- up, in, 1: correct-resolve dependency clear
- recover_idx, in, $clog2(EBR_NUM): branch slot index
- depen_rob, in, $clog2(ROB_DEPTH)+1: branch ROB tag
- iss_valid, out, [ISSUE_W]: lane k issues this cycle
- iss_data, out, res_station_t [ISSUE_W]: issued entry, '0 when not valid
- free_cnt, out, $clog2(RES_DEPTH)+1: number of free slots (registered count)
- empty, out, 1: free_cnt == RES_DEPTH

## Operation
- Slot allocation:
  - Each cycle, accepted enq ports (enq_valid & enq_ready & !early_flush) are assigned the lowest-index free slots, in port order.
  - Port p with enq_valid low consumes no slot.
- Age matrix, older[i][j] = 1 when slot i is older than slot j:
  - On allocating slot s, set older[x][s] = 1 for every occupied x, and for every same-cycle port with a lower index.
  - Clear row s and column s.
- Ready condition: valid & ps1_valid & ps2_valid, evaluated on registered state.
- Select:
  - A ready slot r is the k-th oldest when exactly k ready slots are older than r.
  - The k-th oldest ready entry goes to the k-th lane (ascending index) with fu_ready high.
  - Lanes with fu_ready low output iss_valid=0.
  - Issued slots are freed at the clock edge.
- Wakeup, for each valid slot and each lane i with cdb_valid[i]: if ps1_idx == cdb_pd_array[i], set ps1_valid; same for ps2.
- Wakeup on enqueue: enq_data sources are compared against the same-cycle CDB, so a broadcast coinciding with dispatch is never lost.
- early_flush:
  - Any slot with depen.valid[recover_idx] and depen.rob_tags[recover_idx] == depen_rob is freed.
  - Enqueue is suppressed and all iss_valid are forced to 0 that cycle.
- up (ignored when early_flush is high): for matching slots, clear depen.valid[recover_idx]; the slot stays resident.
- Simultaneous events:
  - issue + enqueue: a slot freed by issue is not reusable until the next cycle. enq_ready is based on registered free_cnt.
  - flush wins over wakeup on the same slot.
- Reset (async): all slots invalid, age matrix 0, free_cnt=RES_DEPTH, enq_ready=1, empty=1, iss_valid=0, iss_data='0. Reset asserted mid-operation drops all entries immediately.

## Timing
- Dispatch to earliest issue: 1 cycle, when the sources are already valid or are broadcast in the dispatch cycle.
- CDB broadcast to issue of the dependent: the next cycle (registered wakeup, no combinational bypass to select).
- iss_* are combinational from registered state plus fu_ready and early_flush; the consumer latches them at the edge.
- free_cnt / enq_ready / empty update one cycle after the issue, enqueue or flush event.

## Structure
- res_station_t, CDB_NUM, P_REG_NUM, EBR_NUM and ROB_DEPTH stay in CDB_types.
- Add a ms_issue_sel_t helper struct for per-lane select results to the same package.
- One sub-module, rs_age_select: age matrix, ready vector and fu_ready in; per-lane one-hot grant out. Parameters RES_DEPTH and ISSUE_W.
- Slot storage, wakeup, allocation and flush stay in res_station_ms.

## Test plan
- Reset then single enqueue:
  - Stimulus: rst_n low mid-cycle, then one enqueue with both sources valid.
  - Expect iss_valid[0]=1 the next cycle, free_cnt returns to RES_DEPTH, empty=1.
- Oldest-first:
  - Stimulus: enqueue A (ps1 tag 5, not ready) then B (ready), then broadcast tag 5.
  - Expect B issued on lane 0 first. Expect A issued the cycle after the broadcast, on lane 0.
- Dual issue with lane gaps:
  - Stimulus: 3 ready entries, fu_ready=2'b10.
  - Expect only lane 1 to issue, carrying the oldest. With fu_ready=2'b11 the next cycle, the two remaining issue oldest to lane 0.
- Same-cycle CDB at enqueue:
  - Stimulus: dispatch ps2=tag 9 while cdb_valid[0]=1 with pd=9.
  - Expect the entry to issue the next cycle.
- Full:
  - Stimulus: fill RES_DEPTH=8 with unready entries.
  - Expect free_cnt=0, enq_ready=0, and further enq_valid ignored. One issue makes enq_ready high only after free_cnt ≥ 2.
- Flush vs up:
  - Stimulus: 4 entries, 2 depending on branch (recover_idx=1, depen_rob=3); early_flush.
  - Expect both freed and free_cnt +2 the next cycle. Repeating with up instead, expect the entries kept with depen.valid[1]=0.
